// File: rtl/local_pattern_table.sv
// Second-level table of a two-level local branch predictor: 2**HIST_W 2-bit
// saturating counters with registered lookup, write-first training and perf counters.
module local_pattern_table #(
  parameter int HIST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  input  logic [HIST_W-1:0] rd_hist,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [1:0]        pred_ctr,
  input  logic              upd_valid,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic [CNT_W-1:0]  upd_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int TBL = 1 << HIST_W;
  localparam logic [1:0] CTR_RESET = 2'b01;

  // Post-update value of every entry; lookups read this so a same-index
  // update in the same cycle is visible to the read (write-first).
  logic [1:0] w_ctr_next [TBL];

  genvar gi;
  generate
    for (gi = 0; gi < TBL; gi++) begin : g_entry
      logic [1:0] r_ctr;
      logic [1:0] w_ctr_upd;
      logic       w_hit;

      assign w_hit = upd_valid && (upd_hist == HIST_W'(gi));

      always_comb begin
        w_ctr_upd = r_ctr;
        if (w_hit) begin
          if (upd_taken) begin
            if (r_ctr != 2'b11) w_ctr_upd = r_ctr + 2'd1;
          end else begin
            if (r_ctr != 2'b00) w_ctr_upd = r_ctr - 2'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) r_ctr <= CTR_RESET;
        else     r_ctr <= w_ctr_upd;
      end

      assign w_ctr_next[gi] = w_ctr_upd;
    end
  endgenerate

  logic             r_pred_valid;
  logic [1:0]       r_pred_ctr;
  logic [CNT_W-1:0] r_upd_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  // pred_ctr/pred_taken deliberately hold their last value when no lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_pred_ctr   <= CTR_RESET;
    end else begin
      r_pred_valid <= rd_valid;
      if (rd_valid) r_pred_ctr <= w_ctr_next[rd_hist];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_cnt     <= '0;
      r_mispred_cnt <= '0;
    end else if (upd_valid) begin
      if (r_upd_cnt != '1) r_upd_cnt <= r_upd_cnt + 1'b1;
      if (upd_mispredict && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_ctr    = r_pred_ctr;
  assign pred_taken  = r_pred_ctr[1];
  assign upd_cnt     = r_upd_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_local_pattern_table.sv
// Scoreboard bench for local_pattern_table: a behavioural model pushes the
// expected outputs of each driven cycle, the tasks pop and compare after the edge.
module tb_local_pattern_table;

  localparam int HIST_W = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_valid;
  logic [HIST_W-1:0] rd_hist;
  logic              pred_valid;
  logic              pred_taken;
  logic [1:0]        pred_ctr;
  logic              upd_valid;
  logic [HIST_W-1:0] upd_hist;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [CNT_W-1:0]  upd_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  local_pattern_table #(.HIST_W(HIST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_hist(rd_hist),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_hist(upd_hist), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict),
    .upd_cnt(upd_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             pv;
    logic [1:0]       pc;
    logic [CNT_W-1:0] uc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  logic [1:0]       m_ctr [16];
  logic             m_pv;
  logic [1:0]       m_pc;
  logic [CNT_W-1:0] m_uc;
  logic [CNT_W-1:0] m_mc;

  // Drives one cycle, advances the model, pushes its expectation, and
  // returns 1ns after the sampling edge.
  task automatic drive(input logic r, input logic rv, input logic [3:0] rh,
                       input logic uv, input logic [3:0] uh, input logic ut,
                       input logic um);
    exp_t x;
    rst = r; rd_valid = rv; rd_hist = rh;
    upd_valid = uv; upd_hist = uh; upd_taken = ut; upd_mispredict = um;
    if (r) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 2'b01;
      m_pv = 1'b0; m_pc = 2'b01; m_uc = '0; m_mc = '0;
    end else begin
      if (uv) begin
        if (m_uc != {CNT_W{1'b1}}) m_uc = m_uc + 1'b1;
        if (um && m_mc != {CNT_W{1'b1}}) m_mc = m_mc + 1'b1;
        if (ut && m_ctr[uh] != 2'd3) m_ctr[uh] = m_ctr[uh] + 2'd1;
        else if (!ut && m_ctr[uh] != 2'd0) m_ctr[uh] = m_ctr[uh] - 2'd1;
      end
      m_pv = rv;
      if (rv) m_pc = m_ctr[rh];
    end
    x.pv = m_pv; x.pc = m_pc; x.uc = m_uc; x.mc = m_mc;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'hx, 1'b0, 4'hx, 1'bx, 1'bx);
    void'(sb.pop_front());
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (pred_valid !== 1'b0 || pred_ctr !== 2'b01 || pred_taken !== 1'b0 ||
        upd_cnt !== 4'd0 || mispred_cnt !== 4'd0 || e.pv !== 1'b0) begin
      failures++;
      $display("FAIL reset: got pv=%b ctr=%b tk=%b uc=%0d mc=%0d want pv=0 ctr=01 tk=0 uc=0 mc=0",
               pred_valid, pred_ctr, pred_taken, upd_cnt, mispred_cnt);
    end
    $display("reset: pv=%b ctr=%b uc=%0d mc=%0d", pred_valid, pred_ctr, upd_cnt, mispred_cnt);
  endtask

  task automatic test_lookup();
    drive(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || pred_ctr !== 2'b01 || pred_taken !== 1'b0 || pred_ctr !== e.pc) begin
      failures++;
      $display("FAIL lookup5: got pv=%b ctr=%b tk=%b want pv=1 ctr=01 tk=0", pred_valid, pred_ctr, pred_taken);
    end
    drive(1'b0, 1'b0, 4'hx, 1'b0, 4'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_valid !== 1'b0 || pred_ctr !== 2'b01 || pred_taken !== 1'b0 || pred_valid !== e.pv) begin
      failures++;
      $display("FAIL idle_hold: got pv=%b ctr=%b tk=%b want pv=0 ctr=01 tk=0", pred_valid, pred_ctr, pred_taken);
    end
    $display("lookup: hist=5 ctr=%b then idle pv=%b", pred_ctr, pred_valid);
  endtask

  task automatic test_saturate();
    logic [1:0] want [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    int n_upd [4] = '{3, 1, 4, 1};
    logic dir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < n_upd[s]; k++) begin
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h3, dir[s], 1'b0);
        void'(sb.pop_front());
      end
      drive(1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (pred_valid !== 1'b1 || pred_ctr !== want[s] || pred_taken !== want[s][1] || pred_ctr !== e.pc) begin
        failures++;
        $display("FAIL saturate step%0d: got ctr=%b tk=%b want ctr=%b", s, pred_ctr, pred_taken, want[s]);
      end
      $display("saturate step%0d: hist=3 ctr=%b", s, pred_ctr);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 4'hA, 1'b1, 4'hA, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_ctr !== 2'b10 || pred_taken !== 1'b1 || pred_ctr !== e.pc) begin
      failures++;
      $display("FAIL bypass_same: got ctr=%b tk=%b want ctr=10 tk=1", pred_ctr, pred_taken);
    end
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 4'hA, 1'b1, 4'hB, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_ctr !== 2'b01 || pred_ctr !== e.pc) begin
      failures++;
      $display("FAIL bypass_diff: got ctr=%b want ctr=01", pred_ctr);
    end
    drive(1'b0, 1'b1, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_ctr !== 2'b10 || pred_ctr !== e.pc) begin
      failures++;
      $display("FAIL ctrB: got ctr=%b want ctr=10", pred_ctr);
    end
    $display("collision: ctr[B]=%b", pred_ctr);
  endtask

  task automatic test_counters();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 23; i++) begin
      if (i < 20) drive(1'b0, 1'b0, 4'h0, 1'b1, 4'(i), 1'(i % 2), (i < 7));
      else        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'hx, 1'bx, 1'b1);
      e = sb.pop_front();
      checks++;
      if (upd_cnt !== e.uc || mispred_cnt !== e.mc) begin
        failures++;
        $display("FAIL perf_cnt cyc%0d: got uc=%0d mc=%0d want uc=%0d mc=%0d",
                 i, upd_cnt, mispred_cnt, e.uc, e.mc);
      end
    end
    checks++;
    if (upd_cnt !== 4'd15 || mispred_cnt !== 4'd7) begin
      failures++;
      $display("FAIL perf_final: got uc=%0d mc=%0d want uc=15 mc=7", upd_cnt, mispred_cnt);
    end
    $display("counters: uc=%0d mc=%0d", upd_cnt, mispred_cnt);
  endtask

  task automatic test_reset_override();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h7, 1'b1, 1'b1);
      void'(sb.pop_front());
    end
    drive(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_ctr !== 2'b11) begin
      failures++;
      $display("FAIL train7: got ctr=%b want ctr=11", pred_ctr);
    end
    drive(1'b1, 1'b1, 4'h7, 1'b1, 4'h7, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (pred_valid !== 1'b0 || upd_cnt !== 4'd0 || mispred_cnt !== 4'd0 || pred_ctr !== 2'b01) begin
      failures++;
      $display("FAIL rst_override: got pv=%b ctr=%b uc=%0d mc=%0d want pv=0 ctr=01 uc=0 mc=0",
               pred_valid, pred_ctr, upd_cnt, mispred_cnt);
    end
    drive(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (pred_valid !== 1'b1 || pred_ctr !== 2'b01 || pred_ctr !== e.pc) begin
      failures++;
      $display("FAIL post_rst7: got pv=%b ctr=%b want pv=1 ctr=01", pred_valid, pred_ctr);
    end
    $display("reset_override: post-reset ctr[7]=%b", pred_ctr);
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    logic       rv, uv, ut, um;
    logic [3:0] rh, uh;
    for (int i = 0; i < 10000; i++) begin
      rv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      um = 1'($urandom_range(0, 1));
      rh = 4'($urandom_range(0, 15));
      uh = ($urandom_range(0, 1) == 1) ? rh : 4'($urandom_range(0, 15));
      drive(1'b0, rv, rh, uv, uh, ut, um);
      e = sb.pop_front();
      checks++;
      if (pred_valid !== e.pv || pred_ctr !== e.pc || pred_taken !== e.pc[1] ||
          upd_cnt !== e.uc || mispred_cnt !== e.mc) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc%0d: got pv=%b ctr=%b uc=%0d mc=%0d want pv=%b ctr=%b uc=%0d mc=%0d",
                   i, pred_valid, pred_ctr, upd_cnt, mispred_cnt, e.pv, e.pc, e.uc, e.mc);
      end
    end
    $display("random: 10000 cycles, %0d mismatching cycles", errs);
  endtask

  initial begin
    rst = 1'b1; rd_valid = 1'b0; rd_hist = '0;
    upd_valid = 1'b0; upd_hist = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lookup();
    test_saturate();
    test_collision();
    test_counters();
    test_reset_override();
    idle();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
